// File: rtl/instr_encoder_pkg.sv
// Shared field layout and opcode set for the block instruction encoder.
// Bit positions live here only so encode and decode cannot drift apart.
package instr_encoder_pkg;

  localparam int BLOCK_INSTR_OP_WIDTH = 5;
  localparam int BLOCK_REG_ADDR_WIDTH = 4;
  localparam int SHIFT_WIDTH          = 6;
  localparam int BLOCK_PMS_WIDTH      = 5;
  localparam int BLOCK_RES_ADDR_WIDTH = 6;
  localparam int BLOCK_INSTR_WIDTH    = 32;

  localparam int O = BLOCK_INSTR_OP_WIDTH;
  localparam int R = BLOCK_REG_ADDR_WIDTH;

  localparam int SRC_A_LO  = O;
  localparam int SRC_B_LO  = R + O;
  localparam int FLD_C_LO  = 2 * R + O;
  localparam int FLD_D_LO  = 3 * R + O;
  localparam int INSTR_T   = 4 * R + O;
  localparam int NSAT_BIT  = INSTR_T + 4;
  localparam int PMS_LO    = INSTR_T + 5;
  localparam int FB_FLAG_LO = 3 * R + O;
  localparam int RES_LO    =
    BLOCK_INSTR_WIDTH - BLOCK_RES_ADDR_WIDTH;

  typedef logic [O-1:0] op_t;
  typedef logic [R-1:0] reg_addr_t;
  typedef logic [BLOCK_PMS_WIDTH-1:0] pms_t;
  typedef logic [BLOCK_RES_ADDR_WIDTH-1:0] res_addr_t;
  typedef logic [BLOCK_INSTR_WIDTH-1:0] instr_word_t;

  localparam op_t OP_NOP         = 5'd0;
  localparam op_t OP_ADD         = 5'd1;
  localparam op_t OP_SUB         = 5'd2;
  localparam op_t OP_MUL         = 5'd3;
  localparam op_t OP_MAC         = 5'd4;
  localparam op_t OP_DELAY_READ  = 5'd16;
  localparam op_t OP_DELAY_WRITE = 5'd17;
  localparam op_t OP_SAVE        = 5'd18;
  localparam op_t OP_LOAD        = 5'd19;
  localparam op_t OP_MOV         = 5'd20;

  function automatic logic is_fmt_b(input op_t op);
    return op inside {
      OP_DELAY_READ, OP_DELAY_WRITE,
      OP_SAVE, OP_LOAD, OP_MOV
    };
  endfunction

  typedef struct packed {
    op_t       op;
    reg_addr_t src_a;
    reg_addr_t src_b;
    reg_addr_t src_c;
    reg_addr_t dest;
    logic      src_a_reg;
    logic      src_b_reg;
    logic      src_c_reg;
    logic      dest_reg;
    logic      saturate;
    pms_t      shift;
    res_addr_t res_addr;
    logic      fmt_b;
  } fields_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field-to-word packer for format A and format B words.
// Unused bits of either format are forced to zero.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  fields_t     f,
  output instr_word_t word
);

  always_comb begin
    word = '0;
    word[O-1:0]             = f.op;
    word[SRC_A_LO +: R]     = f.src_a;
    word[SRC_B_LO +: R]     = f.src_b;
    unique case (1'b1)
      f.fmt_b: begin
        word[FLD_C_LO +: R]     = f.dest;
        word[FB_FLAG_LO]        = f.src_a_reg;
        word[FB_FLAG_LO + 1]    = f.src_b_reg;
        word[FB_FLAG_LO + 2]    = f.dest_reg;
        word[RES_LO +: BLOCK_RES_ADDR_WIDTH] =
          f.res_addr;
      end
      default: begin
        word[FLD_C_LO +: R]     = f.src_c;
        word[FLD_D_LO +: R]     = f.dest;
        word[INSTR_T]           = f.src_a_reg;
        word[INSTR_T + 1]       = f.src_b_reg;
        word[INSTR_T + 2]       = f.src_c_reg;
        word[INSTR_T + 3]       = f.dest_reg;
        word[NSAT_BIT]          = ~f.saturate;
        word[PMS_LO +: BLOCK_PMS_WIDTH] = f.shift;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage encoder: stage 1 captures fields and address, stage 2 the word.
// Addresses are handed out at acceptance and ride along with each word.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int N_INSTRS   = 64,
  parameter int ADDR_WIDTH = $clog2(N_INSTRS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prog_start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [O-1:0]           operation,
  input  logic [R-1:0]           src_a,
  input  logic [R-1:0]           src_b,
  input  logic [R-1:0]           src_c,
  input  logic [R-1:0]           dest,
  input  logic                   src_a_reg,
  input  logic                   src_b_reg,
  input  logic                   src_c_reg,
  input  logic                   dest_reg,
  input  logic                   saturate,
  input  logic [SHIFT_WIDTH-1:0] instr_shift,
  input  logic [BLOCK_RES_ADDR_WIDTH-1:0] res_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BLOCK_INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic                   full,
  output logic                   shift_err
);

  localparam logic [ADDR_WIDTH:0] CNT_MAX =
    (ADDR_WIDTH + 1)'(N_INSTRS);

  logic [ADDR_WIDTH:0]   cnt;
  logic                  s1_valid;
  fields_t               s1;
  logic                  s1_ovf;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic                  s1_adv;
  logic                  accept;
  logic                  flush;
  fields_t               in_f;
  logic                  in_ovf;
  instr_word_t           packed_word;

  assign flush    = reset || prog_start;
  assign full     = (cnt == CNT_MAX);
  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !reset && !full && !prog_start
                 && (!s1_valid || s1_adv);
  assign accept   = in_valid && in_ready;

  always_comb begin
    in_f           = '0;
    in_f.op        = operation;
    in_f.src_a     = src_a;
    in_f.src_b     = src_b;
    in_f.src_c     = src_c;
    in_f.dest      = dest;
    in_f.src_a_reg = src_a_reg;
    in_f.src_b_reg = src_b_reg;
    in_f.src_c_reg = src_c_reg;
    in_f.dest_reg  = dest_reg;
    in_f.saturate  = saturate;
    in_f.shift     = instr_shift[BLOCK_PMS_WIDTH-1:0];
    in_f.res_addr  = res_addr;
    in_f.fmt_b     = is_fmt_b(operation);
  end

  // Only format A carries a shift, so format B never flags overflow.
  assign in_ovf = !in_f.fmt_b
    && (|instr_shift[SHIFT_WIDTH-1:BLOCK_PMS_WIDTH]);

  always_ff @(posedge clk) begin
    if (flush)
      cnt <= '0;
    else if (accept)
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (flush)
      s1_valid <= 1'b0;
    else if (accept)
      s1_valid <= 1'b1;
    else if (s1_adv)
      s1_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= '0;
      s1_ovf  <= 1'b0;
      s1_addr <= '0;
    end else if (accept) begin
      s1      <= in_f;
      s1_ovf  <= in_ovf;
      s1_addr <= cnt[ADDR_WIDTH-1:0];
    end
  end

  instr_pack u_pack (
    .f    (s1),
    .word (packed_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
    end else if (prog_start) begin
      out_valid <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= packed_word;
        out_addr  <= s1_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush)
      shift_err <= 1'b0;
    else if (s1_valid && s1_ovf)
      shift_err <= 1'b1;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder with an arithmetic word model
// and an in-order scoreboard of expected words and addresses.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int N  = 64;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic prog_start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [4:0] operation = '0;
  logic [3:0] src_a = '0, src_b = '0;
  logic [3:0] src_c = '0, dest = '0;
  logic src_a_reg = 0, src_b_reg = 0;
  logic src_c_reg = 0, dest_reg = 0;
  logic saturate = 0;
  logic [5:0] instr_shift = '0;
  logic [5:0] res_addr = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [AW-1:0] out_addr;
  logic full;
  logic shift_err;

  instr_encoder #(.N_INSTRS(N)) dut (
    .clk(clk), .reset(reset),
    .prog_start(prog_start),
    .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation),
    .src_a(src_a), .src_b(src_b),
    .src_c(src_c), .dest(dest),
    .src_a_reg(src_a_reg), .src_b_reg(src_b_reg),
    .src_c_reg(src_c_reg), .dest_reg(dest_reg),
    .saturate(saturate),
    .instr_shift(instr_shift),
    .res_addr(res_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .full(full), .shift_err(shift_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    int          addr;
    bit          ovf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  bit exp_err = 0;
  int accepted = 0;
  int popped = 0;
  int last_addr = -1;
  logic o_ir, o_ov, o_full, o_se;
  logic [31:0] o_word;
  logic [AW-1:0] o_addr;

  task automatic check(string tag,
                       logic [63:0] obs,
                       logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic bit ref_fmt_b(logic [4:0] op);
    return op inside {5'd16, 5'd17, 5'd18, 5'd19, 5'd20};
  endfunction

  // Built from field widths with shifts/adds, not from the RTL packer.
  function automatic logic [31:0] ref_word();
    longint w;
    int t;
    t = 4 * 4 + 5;
    w = longint'(operation);
    w += longint'(src_a) << 5;
    w += longint'(src_b) << 9;
    if (ref_fmt_b(operation)) begin
      w += longint'(dest) << 13;
      w += longint'(src_a_reg) << 17;
      w += longint'(src_b_reg) << 18;
      w += longint'(dest_reg) << 19;
      w += longint'(res_addr) << 26;
    end else begin
      w += longint'(src_c) << 13;
      w += longint'(dest) << 17;
      w += longint'(src_a_reg) << t;
      w += longint'(src_b_reg) << (t + 1);
      w += longint'(src_c_reg) << (t + 2);
      w += longint'(dest_reg) << (t + 3);
      w += longint'(1 - int'(saturate)) << (t + 4);
      w += longint'(int'(instr_shift) % 32) << (t + 5);
    end
    return w[31:0];
  endfunction

  task automatic rand_fields();
    operation   = 5'($urandom_range(0, 31));
    src_a       = 4'($urandom);
    src_b       = 4'($urandom);
    src_c       = 4'($urandom);
    dest        = 4'($urandom);
    src_a_reg   = 1'($urandom);
    src_b_reg   = 1'($urandom);
    src_c_reg   = 1'($urandom);
    dest_reg    = 1'($urandom);
    saturate    = 1'($urandom);
    instr_shift = 6'($urandom);
    res_addr    = 6'($urandom);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    o_ir   = in_ready;
    o_ov   = out_valid;
    o_word = out_instr;
    o_addr = out_addr;
    o_full = full;
    o_se   = shift_err;
    if (reset) begin
      q.delete();
      exp_cnt = 0;
      exp_err = 0;
    end else begin
      if (o_ov) begin
        if (q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          check("word", o_word, q[0].w);
          check("addr", o_addr, q[0].addr);
          if (q[0].ovf) exp_err = 1;
          if (out_ready) begin
            last_addr = q[0].addr;
            popped++;
            void'(q.pop_front());
          end
        end
      end
      if (exp_err)
        check("shift_err_set", o_se, 1);
      else if (q.size() == 0)
        check("shift_err_clr", o_se, 0);
      check("full", o_full, exp_cnt == N);
      if (exp_cnt == N)
        check("in_ready_full", o_ir, 0);
      if (prog_start) begin
        check("in_ready_ps", o_ir, 0);
        q.delete();
        exp_cnt = 0;
        exp_err = 0;
      end else if (in_valid && o_ir) begin
        e.w    = ref_word();
        e.addr = exp_cnt;
        e.ovf  = !ref_fmt_b(operation)
              && instr_shift >= 32;
        q.push_back(e);
        exp_cnt++;
        accepted++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ps();
    prog_start = 1'b1;
    in_valid   = 1'b1;
    tick();
    prog_start = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++)
      tick();
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    int a0, p0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", o_ov, 0);
    check("rst_out_instr", o_word, 0);
    check("rst_out_addr", o_addr, 0);
    check("rst_full", o_full, 0);
    check("rst_shift_err", o_se, 0);
    check("rst_in_ready", o_ir, 0);
    reset = 1'b0;
    tick();

    // Format A directed word and latency
    operation = OP_ADD;
    src_a = 1; src_b = 2; src_c = 3; dest = 4;
    src_a_reg = 1; src_b_reg = 1;
    src_c_reg = 1; dest_reg = 1;
    saturate = 1; instr_shift = 2; res_addr = 0;
    in_valid = 1;
    tick();
    check("a_accept", o_ir, 1);
    in_valid = 0;
    tick();
    check("a_lat1", o_ov, 0);
    tick();
    check("a_lat2", o_ov, 1);
    check("a_op", o_word[4:0], OP_ADD);
    check("a_fields", o_word[20:5], 16'h4321);
    check("a_flags", o_word[24:21], 4'hf);
    check("a_nsat", o_word[25], 0);
    check("a_pms", o_word[30:26], 2);
    check("a_addr", o_addr, 0);

    // Format B directed word
    operation = OP_MOV;
    src_a = 5; src_b = 0; src_c = 3; dest = 7;
    src_a_reg = 1; src_b_reg = 0;
    src_c_reg = 1; dest_reg = 1;
    res_addr = 6'h3f;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    tick();
    check("b_valid", o_ov, 1);
    check("b_dest", o_word[16:13], 7);
    check("b_src_a", o_word[8:5], 5);
    check("b_flags", o_word[19:17], 3'b101);
    check("b_no_src_c", o_word[25:20], 0);
    check("b_res", o_word[31:26], 6'h3f);
    check("b_addr", o_addr, 1);
    drain();

    // Eight back-to-back with a four-cycle stall
    pulse_ps();
    a0 = accepted;
    p0 = popped;
    for (int i = 0; i < 14; i++) begin
      in_valid  = (accepted - a0) < 8;
      out_ready = !(i >= 3 && i <= 6);
      rand_fields();
      tick();
    end
    drain();
    check("bb_accepted", accepted - a0, 8);
    check("bb_popped", popped - p0, 8);
    check("bb_last_addr", last_addr, 7);

    // Random traffic with occasional restarts
    for (int i = 0; i < 600; i++) begin
      rand_fields();
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 7);
      prog_start = ($urandom_range(0, 99) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      tick();
    end
    prog_start = 0;
    reset = 0;
    drain();

    // Fill to the limit
    pulse_ps();
    a0 = accepted;
    out_ready = 1;
    for (int i = 0; i < N + 2; i++) begin
      rand_fields();
      in_valid = 1;
      tick();
    end
    for (int i = 0; i < 4; i++)
      tick();
    check("fill_accepted", accepted - a0, N);
    check("fill_full", o_full, 1);
    check("fill_in_ready", o_ir, 0);
    in_valid = 0;
    drain();
    check("fill_last_addr", last_addr, N - 1);

    // Shift range error, then restart drops in-flight
    pulse_ps();
    rand_fields();
    operation = OP_MUL;
    instr_shift = 6'd33;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    tick();
    check("err_valid", o_ov, 1);
    check("err_pms", o_word[30:26], 1);
    check("err_flag", o_se, 1);
    out_ready = 0;
    rand_fields();
    operation = OP_SUB;
    instr_shift = 6'd4;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    tick();
    pulse_ps();
    out_ready = 1;
    tick();
    check("ps_err_clr", o_se, 0);
    check("ps_dropped", o_ov, 0);
    rand_fields();
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    tick();
    check("ps_new_valid", o_ov, 1);
    check("ps_new_addr", o_addr, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
